// File: rtl/pir_zone_alarm_ctrl.sv
// Multi-zone PIR alarm controller: per-zone sync/debounce, arming delay, latched
// zone LEDs, buzzer timeout, 3-digit 7-seg status. Optional macro: PIR_EVENT_COUNT_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_OFF      | system disabled, all outputs cleared, display blank
// ST_ARMING   | exit delay running, detections ignored
// ST_ARMED    | watching all zones, first detection raises the alarm
// ST_ALARM    | buzzer on, detections latch into LED, timeout running
// ST_SILENCED | buzzer off after timeout, LEDs held, unlatched zone re-alarms
module pir_zone_alarm_ctrl #(
  parameter int NUM_ZONES         = 3,
  parameter int DEBOUNCE_CYC      = 4,
  parameter int ARM_DELAY_CYC     = 8,
  parameter int ALARM_TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 turn,
  input  logic                 stop_alarm,
  input  logic [NUM_ZONES-1:0] pir_sensor,
  output logic [NUM_ZONES-1:0] LED,
  output logic                 buzzer,
  output logic [20:0]          display_data
);

  localparam int TMR_MAX = (ARM_DELAY_CYC > ALARM_TIMEOUT_CYC) ? ARM_DELAY_CYC : ALARM_TIMEOUT_CYC;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int DW      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [TW-1:0] ARM_LOAD = TW'(ARM_DELAY_CYC - 1);
  localparam logic [TW-1:0] ALM_LOAD = TW'(ALARM_TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_ARMING   = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ALARM    = 3'd3,
    ST_SILENCED = 3'd4
  } state_t;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  function automatic logic [3:0] popcnt(input logic [NUM_ZONES-1:0] v);
    popcnt = '0;
    for (int i = 0; i < NUM_ZONES; i++) popcnt = popcnt + 4'(v[i]);
  endfunction

  function automatic logic [3:0] lowest(input logic [NUM_ZONES-1:0] v);
    lowest = '0;
    for (int i = NUM_ZONES - 1; i >= 0; i--) if (v[i]) lowest = 4'(i);
  endfunction

  logic [NUM_ZONES-1:0] sync_1, sync_2, det;
  logic [DW-1:0]        db_cnt [NUM_ZONES];

  // det is registered so the count reaching DEBOUNCE_CYC yields exactly one pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= '0;
      sync_2 <= '0;
      det    <= '0;
      for (int i = 0; i < NUM_ZONES; i++) db_cnt[i] <= '0;
    end else begin
      sync_1 <= pir_sensor;
      sync_2 <= sync_1;
      for (int i = 0; i < NUM_ZONES; i++) begin
        if (!sync_2[i])
          db_cnt[i] <= '0;
        else if (db_cnt[i] != DW'(DEBOUNCE_CYC))
          db_cnt[i] <= db_cnt[i] + DW'(1);
        det[i] <= sync_2[i] && (db_cnt[i] == DW'(DEBOUNCE_CYC - 1));
      end
    end
  end

  state_t               state, nxt_state;
  logic [TW-1:0]        timer, nxt_timer;
  logic [NUM_ZONES-1:0] nxt_led;
  logic [3:0]           first_zone, nxt_fz, dig1_val;
  logic [20:0]          nxt_disp;

  always_comb begin
    nxt_state = state;
    nxt_timer = timer;
    nxt_led   = LED;
    nxt_fz    = first_zone;
    if (!turn) begin
      nxt_state = ST_OFF;
      nxt_timer = '0;
      nxt_led   = '0;
      nxt_fz    = '0;
    end else begin
      case (state)
        ST_OFF: begin
          nxt_state = ST_ARMING;
          nxt_timer = ARM_LOAD;
        end
        ST_ARMING: begin
          if (timer == '0) nxt_state = ST_ARMED;
          else             nxt_timer = timer - TW'(1);
        end
        ST_ARMED: begin
          if (|det) begin
            nxt_state = ST_ALARM;
            nxt_led   = LED | det;
            nxt_timer = ALM_LOAD;
            nxt_fz    = lowest(det);
          end
        end
        ST_ALARM: begin
          if (stop_alarm) begin
            nxt_state = ST_ARMING;
            nxt_timer = ARM_LOAD;
            nxt_led   = '0;
            nxt_fz    = '0;
          end else if (|det) begin
            // a detection outranks the timeout; timer parks at zero until a quiet cycle
            nxt_led = LED | det;
            if (timer != '0) nxt_timer = timer - TW'(1);
          end else if (timer == '0) begin
            nxt_state = ST_SILENCED;
          end else begin
            nxt_timer = timer - TW'(1);
          end
        end
        ST_SILENCED: begin
          if (stop_alarm) begin
            nxt_state = ST_ARMING;
            nxt_timer = ARM_LOAD;
            nxt_led   = '0;
            nxt_fz    = '0;
          end else if (|(det & ~LED)) begin
            nxt_state = ST_ALARM;
            nxt_led   = LED | det;
            nxt_timer = ALM_LOAD;
          end
        end
        default: nxt_state = ST_OFF;
      endcase
    end
  end

`ifdef PIR_EVENT_COUNT_EN
  logic [3:0] evt_cnt, nxt_evt;

  always_comb begin
    nxt_evt = evt_cnt;
    if (nxt_state == ST_OFF)
      nxt_evt = '0;
    else if (nxt_state == ST_ALARM && state != ST_ALARM && evt_cnt != 4'd9)
      nxt_evt = evt_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) evt_cnt <= '0;
    else     evt_cnt <= nxt_evt;
  end

  assign dig1_val = nxt_evt;
`else
  assign dig1_val = popcnt(nxt_led);
`endif

  always_comb begin
    nxt_disp = '0;
    if (nxt_state != ST_OFF) begin
      nxt_disp[20:14] = seg7(4'(nxt_state));
      nxt_disp[13:7]  = seg7(dig1_val);
      if (nxt_state == ST_ALARM || nxt_state == ST_SILENCED)
        nxt_disp[6:0] = seg7(nxt_fz + 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_OFF;
      timer        <= '0;
      LED          <= '0;
      buzzer       <= 1'b0;
      first_zone   <= '0;
      display_data <= '0;
    end else begin
      state        <= nxt_state;
      timer        <= nxt_timer;
      LED          <= nxt_led;
      buzzer       <= (nxt_state == ST_ALARM);
      first_zone   <= nxt_fz;
      display_data <= nxt_disp;
    end
  end

endmodule

// File: tb/tb_pir_zone_alarm_ctrl.sv
// Directed scenarios followed by random sensor/stop/turn/reset traffic, every cycle
// compared against a sliding-window behavioural model of the alarm controller.
module tb_pir_zone_alarm_ctrl;
  localparam int NZ = 3;
  localparam int DB = 4;
  localparam int AD = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          turn = 1'b0;
  logic          stop_alarm = 1'b0;
  logic [NZ-1:0] pir_sensor = '0;
  logic [NZ-1:0] LED;
  logic          buzzer;
  logic [20:0]   display_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pir_zone_alarm_ctrl #(
    .NUM_ZONES(NZ), .DEBOUNCE_CYC(DB), .ARM_DELAY_CYC(AD), .ALARM_TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .turn(turn), .stop_alarm(stop_alarm),
    .pir_sensor(pir_sensor), .LED(LED), .buzzer(buzzer), .display_data(display_data)
  );

  // model: q holds the sensor samples of the last DB+3 edges, oldest first
  logic [NZ-1:0] q[$];
  int            ms, el, fz, evt;
  logic [NZ-1:0] mled;

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: seg = 7'b0111111;  1: seg = 7'b0000110;  2: seg = 7'b1011011;
      3: seg = 7'b1001111;  4: seg = 7'b1100110;  5: seg = 7'b1101101;
      6: seg = 7'b1111101;  7: seg = 7'b0000111;  8: seg = 7'b1111111;
      9: seg = 7'b1101111;  default: seg = 7'b0000000;
    endcase
  endfunction

  function automatic int pop(input logic [NZ-1:0] v);
    pop = 0;
    for (int i = 0; i < NZ; i++) pop += int'(v[i]);
  endfunction

  function automatic logic [20:0] mdisp();
    int d1;
`ifdef PIR_EVENT_COUNT_EN
    d1 = evt;
`else
    d1 = pop(mled);
`endif
    if (ms == 0) return '0;
    return {seg(ms), seg(d1), (ms >= 3) ? seg(fz + 1) : 7'b0000000};
  endfunction

  task automatic model_edge();
    logic [NZ-1:0] d;
    logic          run;
    d = '0;
    // detection: sensor was low DB+3 edges ago, then high for DB consecutive edges
    for (int i = 0; i < NZ; i++) begin
      run = (q[0][i] == 1'b0);
      for (int k = 1; k <= DB; k++) if (q[k][i] !== 1'b1) run = 1'b0;
      d[i] = run;
    end
    if (rst) begin
      ms = 0; el = 0; mled = '0; fz = 0; evt = 0;
    end else if (!turn) begin
      ms = 0; el = 0; mled = '0; fz = 0; evt = 0;
    end else begin
      case (ms)
        0: begin ms = 1; el = 0; end
        1: if (el == AD - 1) ms = 2; else el++;
        2: if (d != 0) begin
             ms = 3; el = 0; mled |= d;
             for (int i = NZ - 1; i >= 0; i--) if (d[i]) fz = i;
             if (evt < 9) evt++;
           end
        3: if (stop_alarm) begin ms = 1; el = 0; mled = '0; fz = 0; end
           else if (d != 0) begin mled |= d; if (el < TO - 1) el++; end
           else if (el == TO - 1) ms = 4;
           else el++;
        default: if (stop_alarm) begin ms = 1; el = 0; mled = '0; fz = 0; end
           else if ((d & ~mled) != 0) begin
             ms = 3; el = 0; mled |= d;
             if (evt < 9) evt++;
           end
      endcase
    end
    q.push_back(rst ? '0 : pir_sensor);
    void'(q.pop_front());
    if (rst) for (int k = 0; k < q.size(); k++) q[k] = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("led", 32'(LED), 32'(mled));
    chk("buzzer", 32'(buzzer), 32'(ms == 3));
    chk("display", 32'(display_data), 32'(mdisp()));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int z;
    for (int k = 0; k < DB + 3; k++) q.push_back('0);
    ms = 0; el = 0; fz = 0; evt = 0; mled = '0;

    // reset state
    ticks(2);
    chk("reset_led", 32'(LED), 32'd0);
    chk("reset_buzzer", 32'(buzzer), 32'd0);
    chk("reset_display", 32'(display_data), 32'd0);

    // arming delay: ARMING for 8 cycles, then ARMED
    rst = 1'b0; turn = 1'b1;
    tick();
    chk("arming_dig2", 32'(display_data[20:14]), 32'b0000110);
    ticks(7);
    chk("still_arming", 32'(display_data[20:14]), 32'b0000110);
    tick();
    chk("armed_dig2", 32'(display_data[20:14]), 32'b1011011);

    // short pulse below debounce threshold
    pir_sensor = 3'b010; ticks(3);
    pir_sensor = 3'b000; ticks(8);
    chk("short_pulse_led", 32'(LED), 32'd0);

    // held pulse: alarm exactly DB+2 edges after first high sample
    pir_sensor = 3'b010; ticks(6);
    chk("pre_alarm_buzzer", 32'(buzzer), 32'd0);
    tick();
    chk("alarm_led", 32'(LED), 32'b010);
    chk("alarm_buzzer", 32'(buzzer), 32'd1);
    chk("alarm_dig0", 32'(display_data[6:0]), 32'b1011011);
    pir_sensor = 3'b000; ticks(2);
    stop_alarm = 1'b1; tick();
    stop_alarm = 1'b0;
    chk("stop_led", 32'(LED), 32'd0);
    ticks(9);

    // simultaneous zones 0 and 2
    pir_sensor = 3'b101; ticks(7);
    chk("dual_led", 32'(LED), 32'b101);
    chk("dual_dig0", 32'(display_data[6:0]), 32'b0000110);
    chk("dual_dig1", 32'(display_data[13:7]), 32'b1011011);
    ticks(15);
    chk("timeout_edge_buzzer", 32'(buzzer), 32'd1);
    tick();
    chk("silenced_buzzer", 32'(buzzer), 32'd0);
    chk("silenced_led", 32'(LED), 32'b101);
    chk("silenced_dig2", 32'(display_data[20:14]), 32'b1100110);
    pir_sensor = 3'b010; ticks(7);
    chk("rearm_buzzer", 32'(buzzer), 32'd1);
    chk("rearm_led", 32'(LED), 32'b111);

    // stop_alarm in the same cycle as a fresh detection
    pir_sensor = 3'b000; ticks(3);
    pir_sensor = 3'b100; ticks(6);
    stop_alarm = 1'b1; tick();
    stop_alarm = 1'b0; pir_sensor = 3'b000;
    chk("stop_vs_det_led", 32'(LED), 32'd0);
    chk("stop_vs_det_dig2", 32'(display_data[20:14]), 32'b0000110);
    ticks(9);

    // turn=0 in ALARM
    pir_sensor = 3'b001; ticks(7);
    chk("pre_off_buzzer", 32'(buzzer), 32'd1);
    pir_sensor = 3'b000; turn = 1'b0; tick();
    chk("off_display", 32'(display_data), 32'd0);
    chk("off_led", 32'(LED), 32'd0);
    turn = 1'b1; ticks(9);

`ifdef PIR_EVENT_COUNT_EN
    for (int n = 0; n < 10; n++) begin
      pir_sensor = 3'b001; ticks(7);
      pir_sensor = 3'b000; stop_alarm = 1'b1; tick();
      stop_alarm = 1'b0; ticks(9);
    end
    chk("evt_saturate_dig1", 32'(display_data[13:7]), 32'b1101111);
`endif

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) begin
        z = int'($urandom_range(NZ - 1));
        pir_sensor[z] = ~pir_sensor[z];
      end
      stop_alarm = ($urandom_range(39) == 0);
      turn       = ($urandom_range(299) != 0);
      rst        = ($urandom_range(799) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
